match_event_logger: RTL and testbench

//  Downstream consumer of dual_sequence_detector output y. Timestamps each detection

---
 rtl/match_event_logger.sv | 109 ++++++++++
 tb/tb_match_event_logger.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/match_event_logger.sv
// Timestamps detector match events into a small FIFO for a reader,
// with a saturating event count and a sticky drop flag.
module match_event_logger #(
  parameter int TS_WIDTH  = 16,
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 8,
  parameter int EDGE_MODE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 y,
  input  logic                 rd_en,
  input  logic                 clr,
  output logic [TS_WIDTH-1:0]  rd_data,
  output logic                 rd_valid,
  output logic                 empty,
  output logic                 full,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef logic [AW:0] ptr_t;

  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic                 ydly_q;
  logic [TS_WIDTH-1:0]  mem_q [DEPTH];
  ptr_t                 wptr_q, wptr_d;
  ptr_t                 rptr_q, rptr_d;
  logic                 empty_q, empty_d;
  logic                 full_q, full_d;
  logic [TS_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 ovf_q, ovf_d;

  logic evt, pop, push, drop;

  always_comb begin
    evt  = en & ((EDGE_MODE != 0) ? (y & ~ydly_q) : y);
    pop  = rd_en & ~empty_q;
    // A full FIFO still accepts a push when the same cycle frees a slot
    push = evt & (~full_q | pop);
    drop = evt & ~push;

    ts_d   = en ? ts_q + TS_WIDTH'(1) : ts_q;
    wptr_d = wptr_q + ptr_t'(push);
    rptr_d = rptr_q + ptr_t'(pop);

    empty_d = (wptr_d == rptr_d);
    full_d  = (wptr_d[AW] != rptr_d[AW]) &&
              (wptr_d[AW-1:0] == rptr_d[AW-1:0]);

    rd_valid_d = pop;
    rd_data_d  = pop ? mem_q[rptr_q[AW-1:0]] : rd_data_q;

    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (evt && count_q != CNT_MAX) count_d = count_q + CNT_WIDTH'(1);
      if (drop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q       <= '0;
      ydly_q     <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      ydly_q     <= y;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wptr_q[AW-1:0]] <= ts_q;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_match_event_logger.sv
// Bench for match_event_logger: vector table, queue scoreboard and
// directed sequences for full/drop, enable, clear and reset corners.
module tb_match_event_logger;

  localparam int TSW = 16;
  localparam int D   = 8;
  localparam int CW  = 8;

  logic clk = 1'b0;
  logic reset, en, y, rd_en, clr;

  logic [TSW-1:0] rd_data, l_rd_data;
  logic           rd_valid, l_rd_valid;
  logic           empty, l_empty;
  logic           full, l_full;
  logic [CW-1:0]  count, l_count;
  logic           overflow, l_overflow;

  always #5 clk = ~clk;

  match_event_logger #(
    .TS_WIDTH(TSW), .DEPTH(D), .CNT_WIDTH(CW), .EDGE_MODE(1)
  ) u_dut (
    .clk(clk), .reset(reset), .en(en), .y(y),
    .rd_en(rd_en), .clr(clr),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .empty(empty), .full(full),
    .count(count), .overflow(overflow)
  );

  match_event_logger #(
    .TS_WIDTH(TSW), .DEPTH(D), .CNT_WIDTH(CW), .EDGE_MODE(0)
  ) u_lvl (
    .clk(clk), .reset(reset), .en(en), .y(y),
    .rd_en(rd_en), .clr(clr),
    .rd_data(l_rd_data), .rd_valid(l_rd_valid),
    .empty(l_empty), .full(l_full),
    .count(l_count), .overflow(l_overflow)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [TSW-1:0] m_ts;
  logic           m_prev;
  logic [TSW-1:0] sb [$];
  int             m_cnt;
  logic           m_ovf;
  logic           e_rv;
  logic [TSW-1:0] e_rd;

  typedef struct {
    logic          y;
    logic          rd;
    logic          e_empty;
    logic [CW-1:0] e_cnt;
    logic          e_rv;
    logic [TSW-1:0] e_rd;
  } vec_t;

  vec_t tv [11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle, advance the reference, then check after the edge
  task automatic step(input logic r, input logic e, input logic yy,
                      input logic rd, input logic c);
    logic ev, pop, drop;
    reset = r; en = e; y = yy; rd_en = rd; clr = c;
    if (r) begin
      sb.delete();
      m_ts = '0; m_prev = 1'b0; m_cnt = 0; m_ovf = 1'b0;
      e_rv = 1'b0; e_rd = '0;
    end else begin
      ev   = e && yy && !m_prev;
      pop  = rd && (sb.size() != 0);
      drop = 1'b0;
      e_rv = pop;
      if (pop) e_rd = sb.pop_front();
      if (ev) begin
        if (sb.size() < D) sb.push_back(m_ts);
        else drop = 1'b1;
      end
      if (c) begin
        m_cnt = 0; m_ovf = 1'b0;
      end else begin
        if (ev && m_cnt < 255) m_cnt++;
        if (drop) m_ovf = 1'b1;
      end
      m_prev = yy;
      if (e) m_ts = m_ts + 16'd1;
    end
    @(posedge clk); #1;
    chk("rd_valid", 32'(rd_valid), 32'(e_rv));
    chk("rd_data", 32'(rd_data), 32'(e_rd));
    chk("empty", 32'(empty), 32'(sb.size() == 0));
    chk("full", 32'(full), 32'(sb.size() == D));
    chk("count", 32'(count), 32'(m_cnt));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; y = 1'b0; rd_en = 1'b0; clr = 1'b0;

    //            y  rd emp cnt rv  rd
    tv[0]  = '{1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 16'd0};
    tv[1]  = '{1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 16'd0};
    tv[2]  = '{1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 16'd0};
    tv[3]  = '{1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 16'd0};
    tv[4]  = '{1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 16'd0};
    tv[5]  = '{1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 16'd0};
    tv[6]  = '{1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 16'd0};
    tv[7]  = '{1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 16'd0};
    tv[8]  = '{1'b0, 1'b1, 1'b0, 8'd2, 1'b1, 16'd3};
    tv[9]  = '{1'b0, 1'b1, 1'b1, 8'd2, 1'b1, 16'd7};
    tv[10] = '{1'b0, 1'b1, 1'b1, 8'd2, 1'b0, 16'd7};

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rv", 32'(rd_valid), 32'd0);

    // Edge mode: y high at ts 3-4 and 7, then three reads
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 1'b1, tv[i].y, tv[i].rd, 1'b0);
      chk($sformatf("tv%0d_empty", i), 32'(empty), 32'(tv[i].e_empty));
      chk($sformatf("tv%0d_count", i), 32'(count), 32'(tv[i].e_cnt));
      chk($sformatf("tv%0d_rv", i), 32'(rd_valid), 32'(tv[i].e_rv));
      chk($sformatf("tv%0d_rd", i), 32'(rd_data), 32'(tv[i].e_rd));
    end

    // Level mode: y high at ts 3-4 gives two entries
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lvl_count", 32'(l_count), 32'd2);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("lvl_rv0", 32'(l_rd_valid), 32'd1);
    chk("lvl_rd0", 32'(l_rd_data), 32'd3);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("lvl_rv1", 32'(l_rd_valid), 32'd1);
    chk("lvl_rd1", 32'(l_rd_data), 32'd4);
    chk("lvl_empty", 32'(l_empty), 32'd1);

    // Nine isolated pulses into an 8-deep FIFO
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      if (i == 7) chk("t3_full8", 32'(full), 32'd1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_count", 32'(count), 32'd9);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk($sformatf("t3_rd%0d", i), 32'(rd_data), 32'(2 * i));
    end

    // Full FIFO: simultaneous push and pop
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t4_full", 32'(full), 32'd1);
    chk("t4_ovf", 32'(overflow), 32'd0);
    chk("t4_rd", 32'(rd_data), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t4_rv_empty", 32'(rd_valid), 32'd0);

    // Disabled logging, then clear racing an event
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("t5_empty", 32'(empty), 32'd1);
    chk("t5_count", 32'(count), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t5_ts_frozen", 32'(rd_data), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("t5_clr_count", 32'(count), 32'd0);
    chk("t5_clr_stored", 32'(empty), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t5_clr_rd", 32'(rd_data), 32'd2);

    // Reset with entries pending, then push/pop into empty FIFO
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_count", 32'(count), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t6_rv", 32'(rd_valid), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t6_ts0", 32'(rd_data), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
